// File: rtl/uart_pkg.sv
// uart_pkg: shared parity modes, receiver state encoding and bit-timing helper.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HIGH
   } state_t;

   // Nominal sample tick of frame bit i; i = -1 is the start bit.
   function automatic int sample_tick(input int i, input int os);
      return os / 2 + (i + 1) * os;
   endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: line synchroniser, oversample tick counter and 3-sample majority vote.
module uart_bit_sampler
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic samp_en,
   input  logic in,
   input  logic start,
   input  logic run,
   output logic s,
   output logic bit_valid,
   output logic bit_val
);

   localparam int CW = $clog2(OVERSAMPLE);
   // Decisions fall one tick after each bit middle; that phase repeats every bit.
   localparam logic [CW-1:0] DEC_PH = CW'(sample_tick(-1, OVERSAMPLE) + 1);

   logic [1:0]    sync_q, sync_d;
   logic [1:0]    hist_q, hist_d;
   logic [CW-1:0] cnt_q, cnt_d;

   assign s = sync_q[1];

   always_comb begin
      sync_d = {sync_q[0], in};
      hist_d = samp_en ? {hist_q[0], s} : hist_q;
      cnt_d  = !samp_en ? cnt_q : start ? CW'(1) : run ? cnt_q + 1'b1 : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= 2'b11;
         hist_q <= 2'b11;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bit_valid = samp_en & run & (cnt_q == DEC_PH);
   assign bit_val   = (hist_q[1] & hist_q[0]) | (hist_q[1] & s) | (hist_q[0] & s);

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable oversampled UART receiver with parity, framing and break reporting.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 samp_en,
   input  logic                 in,
   output logic                 ready,
   output logic [DATA_BITS-1:0] out,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 busy
);

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
   localparam bit         HAS_PAR   = PARITY != PAR_NONE;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] out_q, out_d;
   logic                 par_q, par_d;
   logic                 pbit_q, pbit_d;
   logic                 stop_err_q, stop_err_d;
   logic                 ready_q, ready_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 break_det_q, break_det_d;
   logic                 s, bit_valid, bit_val, start, run, stop_err_n;

   assign start = (state_q == ST_IDLE) && !s;
   assign run   = (state_q != ST_IDLE) && (state_q != ST_WAIT_HIGH);

   uart_bit_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
      .clk       (clk),
      .reset     (reset),
      .samp_en   (samp_en),
      .in        (in),
      .start     (start),
      .run       (run),
      .s         (s),
      .bit_valid (bit_valid),
      .bit_val   (bit_val)
   );

   assign stop_err_n = stop_err_q | ~bit_val;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      pbit_d       = pbit_q;
      stop_err_d   = stop_err_q;
      ready_d      = 1'b0;
      out_d        = out_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      break_det_d  = break_det_q;
      case (state_q)
         ST_IDLE: begin
            if (samp_en && !s) begin
               state_d    = ST_START;
               cnt_d      = '0;
               par_d      = 1'b0;
               pbit_d     = 1'b0;
               stop_err_d = 1'b0;
            end
         end
         ST_START: begin
            if (bit_valid) state_d = bit_val ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (bit_valid) begin
               shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
               par_d   = par_q ^ bit_val;
               cnt_d   = (cnt_q == LAST_DATA) ? '0 : cnt_q + 4'd1;
               state_d = (cnt_q != LAST_DATA) ? ST_DATA : HAS_PAR ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (bit_valid) begin
               pbit_d  = bit_val;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_valid) begin
               stop_err_d = stop_err_n;
               cnt_d      = cnt_q + 4'd1;
               if (cnt_q == LAST_STOP) begin
                  ready_d      = 1'b1;
                  out_d        = shift_q;
                  parity_err_d = (PARITY == PAR_ODD)  ? ~(par_q ^ pbit_q) :
                                 (PARITY == PAR_EVEN) ? (par_q ^ pbit_q) : 1'b0;
                  frame_err_d  = stop_err_n;
                  break_det_d  = stop_err_n & ~|shift_q & ~pbit_q;
                  // A low final stop bit leaves the line low; wait for idle before rearming.
                  state_d      = bit_val ? ST_IDLE : ST_WAIT_HIGH;
               end
            end
         end
         ST_WAIT_HIGH: begin
            if (samp_en && s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         pbit_q       <= 1'b0;
         stop_err_q   <= 1'b0;
         ready_q      <= 1'b0;
         out_q        <= '0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         break_det_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         pbit_q       <= pbit_d;
         stop_err_q   <= stop_err_d;
         ready_q      <= ready_d;
         out_q        <= out_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         break_det_q  <= break_det_d;
      end
   end

   assign ready      = ready_q;
   assign out        = out_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign break_det  = break_det_q;
   assign busy       = state_q != ST_IDLE;

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver: successor to the fixed 8N1 receiver. Configurable data width, parity and stop bits. Oversampled, majority-vote bit decisions. Reports parity errors, framing errors and break conditions. Sits between the pin-side input and the host register interface. Runs on one system clock, with a sample-rate enable in place of a separate sample clock.

## Interface
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- OVERSAMPLE, 8: samp_en ticks per bit; power of 2, at least 4.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- samp_en  in  1  one-clk strobe at OVERSAMPLE × baud rate.
- in  in  1  asynchronous serial line, idle high.
- ready  out  1  one-clk pulse when a frame completes.
- out  out  DATA_BITS  received data, LSB first on the wire; held until the next ready.
- parity_err  out  1  valid with ready; held like out.
- frame_err  out  1  valid with ready; held like out.
- break_det  out  1  valid with ready; held like out.
- busy  out  1  high whenever state is not IDLE.

## Operation
- in passes through a 2-FF synchroniser, reset to 1. Call its output s.
- All counters advance only on samp_en. States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- Tick numbering: tick 0 is the first samp_en in IDLE with s = 0; the FSM moves to START on that tick.
- Let H = OVERSAMPLE/2. Nominal sample ticks:
  - start bit: tick H;
  - frame bit i (0 = first data bit): tick H + (i+1)·OVERSAMPLE.
- Bit value = majority of s at ticks t-1, t, t+1. The decision is made at tick t+1.
- START: if the start bit decides 1, this is a false start; return to IDLE with no ready.
- DATA: shift in DATA_BITS bits, LSB first.
- PARITY: present only if PARITY != 0.
  - odd: the XOR of data bits and the parity bit must be 1;
  - even: it must be 0;
  - a mismatch sets parity_err.
- STOP: each stop bit must decide 1; any 0 sets frame_err.
- break_det = all data bits 0, parity bit (if present) 0, and frame_err.
- Completion: on the final stop-bit decision, update out and the three flags and pulse ready.
  - If the final stop bit decided 0, go to WAIT_HIGH.
  - Otherwise go to IDLE.
- WAIT_HIGH: stay until s = 1 on a samp_en tick, then go to IDLE. No new start is accepted here.
- Reset values: state IDLE; out 0; ready, parity_err, frame_err, break_det, busy all 0; counters 0.
- reset mid-frame: abort the frame, no ready pulse, all reset values restored on the next clk.
- samp_en low: state and counters freeze. A s transition with samp_en low is not seen until the next samp_en.

## Timing
- Input latency: 2 clk from in to s.
- ready asserts the clk after the samp_en at tick H + N·OVERSAMPLE + 1, where N = DATA_BITS + (PARITY != 0) + STOP_BITS.
- Default 8N1, OVERSAMPLE = 8: ready at tick 4 + 9·8 + 1 = 77.
- ready lasts exactly one clk. There is no back-pressure. A host that misses the pulse still reads out and the flags until the next frame completes.
- Back-to-back frames: after the last stop decision the FSM is in IDLE. A start edge arriving half a bit after that stop-bit middle is accepted.
- busy rises in the same clk as the IDLE→START transition. It falls in the clk that returns to IDLE.

## Structure
- Shared package uart_pkg holds:
  - parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - the state encoding constants;
  - a function giving the sample tick of frame bit i.
- Sub-module uart_bit_sampler contains the synchroniser, the tick counter and the 3-sample majority vote. It emits a one-clk bit_valid and bit_val to the FSM. It is reusable by a future multi-channel receiver.

## Test plan
- 8N1, samp_en every clk, send 0xA9 then 0x99 back-to-back → two ready pulses; out = 0xA9 then 0x99; all flags 0; ready at tick 77.
- DATA_BITS = 7, even parity, send 0x55 with a wrong parity bit → ready with out = 0x55 and parity_err = 1. The next correct frame clears parity_err.
- 8N1, hold the stop bit low, then release the line 3 bits later → ready with frame_err = 1. busy stays high until s returns to 1, then IDLE.
- Line low for 2 ticks then high (glitch) → no ready, busy returns to 0; a following valid 0x31 frame is received correctly.
- 8N2, line low for 12 bit-times → ready with out = 0x00, frame_err = 1, break_det = 1. No second frame until the line goes high.
- Assert reset for 1 clk during DATA of a 0xEA frame → no ready and all outputs 0. Then 0xB1 sent after the line idles ≥ 1 bit is received correctly. Repeat with samp_en gated off for 101 clks mid-idle: no spurious frame.
